// File: rtl/mem_fwd_history_unit_pkg.sv
// Shared CPU definitions for the MEM-stage store-data forwarding unit:
// default widths, the history-entry record layout and an index-width helper.
package mem_fwd_history_unit_pkg;

    localparam int unsigned CPU_ADDR_W = 5;
    localparam int unsigned CPU_DATA_W = 32;

    // Reference layout of one retired-writer history entry at default widths
    typedef struct packed {
        logic                  valid;
        logic [CPU_ADDR_W-1:0] addr;
        logic [CPU_DATA_W-1:0] data;
    } hist_entry_t;

    function automatic int unsigned src_idx_w(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/mem_fwd_history_unit_fwd_priority_select.sv
// Youngest-first (lowest index wins) match encoder over N forwarding sources,
// returning hit flag, winning source index and its data.
module fwd_priority_select
    import mem_fwd_history_unit_pkg::*;
#(
    parameter int unsigned N      = 3,
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned IDX_W  = 2
) (
    input  logic                       en,
    input  logic [ADDR_W-1:0]          key,
    input  logic [N-1:0]               src_valid,
    input  logic [N-1:0][ADDR_W-1:0]   src_addr,
    input  logic [N-1:0][DATA_W-1:0]   src_data,
    output logic                       hit,
    output logic [IDX_W-1:0]           idx,
    output logic [DATA_W-1:0]          data
);

    logic [N-1:0] match;

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            match[i] = en && src_valid[i] && (src_addr[i] == key);
        end
    end

    // First set bit from index 0 upward wins; no match leaves zeros on idx/data
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (match[i] && !hit) begin
                hit  = 1'b1;
                idx  = IDX_W'(i);
                data = src_data[i];
            end
        end
    end

endmodule

// File: rtl/mem_fwd_history_unit.sv
// MEM-stage store-data forwarding from the live WB stage and a DEPTH-entry
// retired-writer shift history, with a saturating forward-event counter.
module mem_fwd_history_unit
    import mem_fwd_history_unit_pkg::*;
#(
    parameter  int unsigned ADDR_W = CPU_ADDR_W,
    parameter  int unsigned DATA_W = CPU_DATA_W,
    parameter  int unsigned DEPTH  = 2,
    parameter  int unsigned CNT_W  = 16,
    localparam int unsigned SRC_W  = src_idx_w(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              MEM_DATA_MEM_WRITE,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              WB_REG_WRITE,
    input  logic [ADDR_W-1:0] WB_ADDR,
    input  logic [DATA_W-1:0] WB_DATA,
    output logic              MEM_FWD_SEL,
    output logic [DATA_W-1:0] MEM_FWD_DATA,
    output logic [SRC_W-1:0]  MEM_FWD_SRC,
    output logic [CNT_W-1:0]  FWD_COUNT
);

    localparam int unsigned NSRC = DEPTH + 1;

    // Same {valid, addr, data} layout as hist_entry_t, at this instance's widths
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t [DEPTH:1]              hist_q;
    logic   [NSRC-1:0]             src_valid;
    logic   [NSRC-1:0][ADDR_W-1:0] src_addr;
    logic   [NSRC-1:0][DATA_W-1:0] src_data;
    logic                          fwd_en;
    logic                          fwd_hit;
    logic   [SRC_W-1:0]            fwd_idx;
    logic   [DATA_W-1:0]           fwd_data;
    logic   [CNT_W-1:0]            fwd_count_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hist_q <= '0;
        end else if (!STALL) begin
            hist_q[1] <= '{valid: WB_REG_WRITE && (WB_ADDR != '0),
                           addr:  WB_ADDR,
                           data:  WB_DATA};
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                hist_q[k] <= hist_q[k-1];
            end
        end
    end

    // Source 0 is the live WB stage; sources 1..DEPTH are history entries
    always_comb begin
        src_valid[0] = WB_REG_WRITE;
        src_addr[0]  = WB_ADDR;
        src_data[0]  = WB_DATA;
        for (int unsigned k = 1; k <= DEPTH; k++) begin
            src_valid[k] = hist_q[k].valid;
            src_addr[k]  = hist_q[k].addr;
            src_data[k]  = hist_q[k].data;
        end
    end

    // Gating with RESET keeps a live WB match from leaking out during reset
    assign fwd_en = MEM_DATA_MEM_WRITE && (MEM_ADDR != '0) && !RESET;

    fwd_priority_select #(
        .N      (NSRC),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .IDX_W  (SRC_W)
    ) u_select (
        .en        (fwd_en),
        .key       (MEM_ADDR),
        .src_valid (src_valid),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .hit       (fwd_hit),
        .idx       (fwd_idx),
        .data      (fwd_data)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fwd_count_q <= '0;
        end else if (!STALL && fwd_hit && (fwd_count_q != '1)) begin
            fwd_count_q <= fwd_count_q + CNT_W'(1);
        end
    end

    assign MEM_FWD_SEL  = fwd_hit;
    assign MEM_FWD_DATA = fwd_data;
    assign MEM_FWD_SRC  = fwd_idx;
    assign FWD_COUNT    = fwd_count_q;

endmodule

// File: doc/mem_fwd_history_unit.md
Name: mem_fwd_history_unit

Overview:
- Parametrised load/store data-forwarding unit for the 5-stage CPU pipeline, sitting beside the MEM stage.
- Detects a store in MEM whose data register is written by the instruction in WB. It also detects a match against any of the last DEPTH retired writers, held in a shift history that covers register-file write/read latency.
- Supplies the forwarded store data and a source index, and keeps a saturating forward-event counter for the performance monitor.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, data width.
- DEPTH, 2, number of retired-writer history entries beyond the live WB stage (minimum 1).
- CNT_W, 16, width of the forward-event counter.

Ports:
- CLK  input  1  pipeline clock.
- RESET  input  1  asynchronous, active-high reset.
- STALL  input  1  pipeline hold; high freezes the history and counter.
- MEM_DATA_MEM_WRITE  input  1  instruction in MEM is a store.
- MEM_ADDR  input  ADDR_W  store-data source register (rs2) of the MEM instruction.
- WB_REG_WRITE  input  1  instruction in WB writes the register file.
- WB_ADDR  input  ADDR_W  destination register of the WB instruction.
- WB_DATA  input  DATA_W  final write-back value of the WB instruction (load data or ALU result).
- MEM_FWD_SEL  output  1  1 = MEM store data must be taken from MEM_FWD_DATA.
- MEM_FWD_DATA  output  DATA_W  forwarded store data.
- MEM_FWD_SRC  output  clog2(DEPTH+1)  0 = live WB, k = history entry k (1 = youngest).
- FWD_COUNT  output  CNT_W  saturating count of cycles with a forward taken.

Behaviour:
- History entries 1..DEPTH each hold {valid, addr, data}; entry 1 is the youngest.
- RESET asserted (asynchronous): all history valid bits = 0 and FWD_COUNT = 0.
  - MEM_FWD_SEL = 0, MEM_FWD_DATA = 0 and MEM_FWD_SRC = 0 while RESET is high, regardless of other inputs.
- Each rising CLK edge with STALL = 0:
  - entry k+1 takes entry k;
  - entry 1 takes {WB_REG_WRITE && WB_ADDR != 0, WB_ADDR, WB_DATA};
  - the oldest entry is discarded.
- STALL = 1: the history holds.
- Match source s is valid when all of the following hold:
  - MEM_DATA_MEM_WRITE = 1;
  - MEM_ADDR != 0 (x0 never forwards);
  - for s = 0: WB_REG_WRITE = 1 and WB_ADDR == MEM_ADDR;
  - for s >= 1: entry valid and entry addr == MEM_ADDR.
- Selection is a priority on the youngest source: live WB first, then entry 1, 2, ... DEPTH.
  - MEM_FWD_SEL = any match.
  - MEM_FWD_DATA = data of the selected source.
  - MEM_FWD_SRC = index of the selected source.
  - With no match, MEM_FWD_DATA = 0 and MEM_FWD_SRC = 0.
- All selection outputs are combinational (zero latency) from the inputs and the history registers. The outputs are evaluated during STALL as well.
- Address compares are 2-state equality on ADDR_W bits.
- FWD_COUNT: on a clock edge with STALL = 0 and MEM_FWD_SEL = 1, the counter increments by 1. It saturates at 2^CNT_W−1 and never wraps.
- Simultaneous events:
  - A WB match and a history match on the same address: WB wins (newest value).
  - Two history entries with the same address: the lower index wins.
- RESET mid-operation: history cleared immediately; forwarding resumes only from new WB writes after RESET deasserts.

Decomposition:
- Shared cpu package: ADDR_W and DATA_W defaults, and the history-entry record layout {valid, addr, data}.
- One natural sub-module, fwd_priority_select: a parametrised (DEPTH+1)-way youngest-first match encoder returning hit, index, and data.
- The top level holds the shift history and the counter.

Test Plan:
- Reset, then store with MEM_ADDR=5 while WB writes x5=0xDEADBEEF -> SEL=1, DATA=0xDEADBEEF, SRC=0; FWD_COUNT=1 after the next edge.
- WB writes x7=0x11 in cycle n, bubble in WB at n+1, store MEM_ADDR=7 at n+1 -> SEL=1, DATA=0x11, SRC=1; with DEPTH=2 at n+2 -> SRC=2; at n+3 -> SEL=0.
- WB writes x3=0xA at n and x3=0xB at n+1, store MEM_ADDR=3 at n+2 -> DATA=0xB, SRC=1 (youngest wins).
- WB writes x0=0x55, then a store with MEM_ADDR=0 -> SEL=0, FWD_COUNT unchanged.
- x9=0x99 written, STALL=1 held for 3 cycles with store MEM_ADDR=9 -> SRC stays 1 and FWD_COUNT unchanged; after STALL drops -> counter +1.
- RESET pulsed mid-cycle with a valid history match -> outputs 0 immediately and history invalid. Separately, with CNT_W=4, force 20 forwards -> FWD_COUNT=15.
